// File: rtl/bcd_disp_if.sv
// Handshake and display bundle for bcd_disp_ctrl: operand/start in; busy/done/bcd and the
// scanned 7-segment drive out.
interface bcd_disp_if;
    logic [9:0]  bin;
    logic        start;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    modport master (
        output bin,
        output start,
        input  busy,
        input  done,
        input  bcd,
        input  an,
        input  seg,
        input  dp
    );

    modport slave (
        input  bin,
        input  start,
        output busy,
        output done,
        output bcd,
        output an,
        output seg,
        output dp
    );
endinterface

// File: rtl/bcd_disp_ctrl.sv
// Sequential 10-bit binary-to-BCD converter (double-dabble) with a 4-digit common-anode scan.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits on seg.
module bcd_disp_ctrl #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic     clk,
    input  logic     rst_n,
    bcd_disp_if.slave io
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] REF_MAX = CW'(REFRESH_DIV - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [9:0]   shift_q, shift_d;
    logic [15:0]  work_q, work_d;
    logic [3:0]   iter_q, iter_d;
    logic [15:0]  bcd_q, bcd_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic [CW-1:0] ref_q, ref_d;
    logic [1:0]    dig_q, dig_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic [15:0]   work_next_s;
    logic          wrap_s;

    function automatic logic [15:0] add3_all(input logic [15:0] w);
        logic [15:0] r;
        r = w;
        for (int i = 0; i < 4; i++) begin
            if (w[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = w[i*4 +: 4] + 4'd3;
            end else begin
                r[i*4 +: 4] = w[i*4 +: 4];
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    function automatic logic [6:0] digit_seg(input logic [15:0] v, input logic [1:0] idx);
        logic [3:0] nib;
        logic       blank;
        case (idx)
            2'd0:    nib = v[3:0];
            2'd1:    nib = v[7:4];
            2'd2:    nib = v[11:8];
            2'd3:    nib = v[15:12];
            default: nib = 4'd0;
        endcase
        blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        // A digit is a leading zero when it and every digit above it are zero.
        case (idx)
            2'd1:    blank = (v[15:4] == 12'd0);
            2'd2:    blank = (v[15:8] == 8'd0);
            2'd3:    blank = (v[15:12] == 4'd0);
            default: blank = 1'b0;
        endcase
`endif
        return blank ? 7'b1111111 : seg7(nib);
    endfunction

    function automatic logic [3:0] an_for(input logic [1:0] idx);
        logic [3:0] a;
        case (idx)
            2'd0:    a = 4'b1110;
            2'd1:    a = 4'b1101;
            2'd2:    a = 4'b1011;
            2'd3:    a = 4'b0111;
            default: a = 4'b1111;
        endcase
        return a;
    endfunction

    assign work_next_s = {add3_all(work_q)[14:0], shift_q[9]};

    // Conversion FSM next-state and datapath.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        work_d  = work_q;
        iter_d  = iter_q;
        bcd_d   = bcd_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (io.start) begin
                    shift_d = io.bin;
                    work_d  = 16'h0000;
                    iter_d  = 4'd0;
                    state_d = ST_CONV;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CONV: begin
                work_d  = work_next_s;
                shift_d = {shift_q[8:0], 1'b0};
                iter_d  = iter_q + 4'd1;
                // busy is registered from the iteration count, so it rises one edge after acceptance.
                if (iter_q == 4'd9) begin
                    bcd_d   = work_next_s;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    busy_d  = 1'b1;
                    state_d = ST_CONV;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Conversion state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            shift_q <= 10'd0;
            work_q  <= 16'h0000;
            iter_q  <= 4'd0;
            bcd_q   <= 16'h0000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            work_q  <= work_d;
            iter_q  <= iter_d;
            bcd_q   <= bcd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign wrap_s = (ref_q == REF_MAX);

    // Display scan: refresh counter, digit index and the registered an/seg drive.
    always_comb begin
        ref_d = ref_q;
        dig_d = dig_q;
        an_d  = an_q;
        seg_d = seg_q;
        dp_d  = 1'b1;
        if (wrap_s) begin
            ref_d = {CW{1'b0}};
            dig_d = dig_q + 2'd1;
            an_d  = an_for(dig_q + 2'd1);
            seg_d = digit_seg(bcd_q, dig_q + 2'd1);
        end else begin
            ref_d = ref_q + CW'(1);
        end
    end

    // Display scan registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_q <= {CW{1'b0}};
            dig_q <= 2'd0;
            an_q  <= 4'b1110;
            seg_q <= 7'b1000000;
            dp_q  <= 1'b1;
        end else begin
            ref_q <= ref_d;
            dig_q <= dig_d;
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign io.busy = busy_q;
    assign io.done = done_q;
    assign io.bcd  = bcd_q;
    assign io.an   = an_q;
    assign io.seg  = seg_q;
    assign io.dp   = dp_q;

endmodule

// File: tb/tb_bcd_disp_ctrl.sv
// Scoreboard bench for bcd_disp_ctrl: a cycle-level behavioural model predicts acceptance,
// busy/done timing, the bcd value and the scanned display; a negedge monitor compares.
module tb_bcd_disp_ctrl;

    localparam int D = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bcd_disp_if io();

    bcd_disp_ctrl #(.REFRESH_DIV(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    int cyc = 0;
    int acc_edge = -1000;
    int pend_val = 0;
    bit pend = 1'b0;
    int disp_val = 0;
    int shown_val = 0;
    int shown_dig = 0;
    int p = 0;
    int sbq[$];

    function automatic int to_bcd(input int v);
        return (((v / 1000) % 10) << 12) | (((v / 100) % 10) << 8) |
               (((v / 10) % 10) << 4) | (v % 10);
    endfunction

    function automatic int exp_seg(input int v, input int dig);
        int tbl[10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        int pw;
        pw = (dig == 0) ? 1 : (dig == 1) ? 10 : (dig == 2) ? 100 : 1000;
`ifdef LEADING_ZERO_BLANK_EN
        if (dig > 0 && v < pw) return 7'b1111111;
`endif
        return tbl[(v / pw) % 10];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // Reference model: advances on each rising edge from the driven inputs only.
    always @(posedge clk) begin
        if (!rst_n) begin
            acc_edge = -1000;
            pend = 1'b0;
            disp_val = 0;
            shown_val = 0;
            shown_dig = 0;
            p = 0;
            sbq.delete();
        end else begin
            cyc++;
            p++;
            if (p % D == 0) begin
                shown_dig = (p / D) % 4;
                shown_val = disp_val;
            end
            if (pend && cyc == acc_edge + 10) begin
                disp_val = pend_val;
                pend = 1'b0;
            end
            if (io.start && cyc >= acc_edge + 11) begin
                acc_edge = cyc;
                pend = 1'b1;
                pend_val = int'(io.bin);
                sbq.push_back(int'(io.bin));
            end
        end
    end

    // Monitor: compares DUT outputs with the model away from the active edge.
    always @(negedge clk) begin
        int v;
        if (!rst_n) begin
            chk("rst_busy", {31'd0, io.busy}, 32'd0);
            chk("rst_done", {31'd0, io.done}, 32'd0);
            chk("rst_bcd",  {16'd0, io.bcd}, 32'h0000);
            chk("rst_an",   {28'd0, io.an}, 32'b1110);
            chk("rst_seg",  {25'd0, io.seg}, 32'b1000000);
            chk("rst_dp",   {31'd0, io.dp}, 32'd1);
        end else begin
            chk("busy", {31'd0, io.busy},
                32'((cyc >= acc_edge + 1) && (cyc <= acc_edge + 9)));
            chk("done", {31'd0, io.done}, 32'(cyc == acc_edge + 10));
            chk("bcd_hold", {16'd0, io.bcd}, 32'(to_bcd(disp_val)));
            chk("an",  {28'd0, io.an}, 32'((~(4'b0001 << shown_dig)) & 4'hF));
            chk("seg", {25'd0, io.seg}, 32'(exp_seg(shown_val, shown_dig)));
            chk("dp",  {31'd0, io.dp}, 32'd1);
            if (io.done) begin
                if (sbq.size() == 0) begin
                    chk("sb_nonempty_on_done", 32'd0, 32'd1);
                end else begin
                    v = sbq.pop_front();
                    chk("bcd_on_done", {16'd0, io.bcd}, 32'(to_bcd(v)));
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic conv(input int v);
        io.bin = 10'(v);
        io.start = 1'b1;
        step(1);
        io.start = 1'b0;
        io.bin = 10'($urandom_range(0, 1023));
        step(12);
    endtask

    initial begin
        io.bin = 10'd0;
        io.start = 1'b0;
        rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(20);

        conv(1023);
        conv(0);
        conv(999);
        conv(1000);
        conv(5);

        // start held across a conversion, operand changed mid-run
        io.bin = 10'd512;
        io.start = 1'b1;
        step(4);
        io.bin = 10'd7;
        step(25);
        io.start = 1'b0;
        step(12);

        // reset in the middle of a conversion
        io.bin = 10'd777;
        io.start = 1'b1;
        step(1);
        io.start = 1'b0;
        step(5);
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        conv(777);

        // display scan with a small stable value
        conv(42);
        step(40);
        conv(7);
        step(20);

        for (int i = 0; i < 40; i++) begin
            io.bin = 10'($urandom_range(0, 1023));
            io.start = 1'b1;
            step($urandom_range(1, 3));
            io.start = 1'b0;
            for (int g = $urandom_range(0, 14); g > 0; g--) begin
                io.bin = 10'($urandom_range(0, 1023));
                step(1);
            end
        end

        step(15);
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
